instr_encoder: RTL and testbench

RV32I instruction encoder and program-stream generator: accepts symbolic instruction requests (operation index, register numbers, immediate) over a valid/ready handshake and emits the packed 32-bit machine word with a sequential word address. It is the inverse of the core's instruction decoder. It feeds instruction memory during program load and self-test generation, and its output words must decode back to the same operation, registers and immediate in the decoder.

---
 rtl/instr_encoder.sv | 163 ++++++++++++++++
 tb/tb_instr_encoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I encoder: symbolic request -> packed machine word with a sequential word address.
// Optional immediate range checking is compiled in with `define ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              err_range,
    input  logic              err_clr
);
    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_X} fmt_e;

    fmt_e        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] word;
    logic        legal, imm_ok, accept, fire;
    logic [ADDR_W-1:0] cur_addr;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d, next_addr_q, next_addr_d;
    logic              err_illegal_q, err_illegal_d;

    // Operation index -> format, major opcode, funct3 and the funct7 bit-30 flag.
    always_comb begin
        fmt = F_X; opc = 7'h00; f3 = 3'd0; alt = 1'b0;
        case (in_op)
            6'd0:  begin fmt = F_U;  opc = 7'h37; end
            6'd1:  begin fmt = F_U;  opc = 7'h17; end
            6'd2:  begin fmt = F_J;  opc = 7'h6F; end
            6'd3:  begin fmt = F_I;  opc = 7'h67; end
            6'd4:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd0; end
            6'd5:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd1; end
            6'd6:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd4; end
            6'd7:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd5; end
            6'd8:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd6; end
            6'd9:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd7; end
            6'd10: begin fmt = F_I;  opc = 7'h03; f3 = 3'd0; end
            6'd11: begin fmt = F_I;  opc = 7'h03; f3 = 3'd1; end
            6'd12: begin fmt = F_I;  opc = 7'h03; f3 = 3'd2; end
            6'd13: begin fmt = F_I;  opc = 7'h03; f3 = 3'd4; end
            6'd14: begin fmt = F_I;  opc = 7'h03; f3 = 3'd5; end
            6'd15: begin fmt = F_S;  opc = 7'h23; f3 = 3'd0; end
            6'd16: begin fmt = F_S;  opc = 7'h23; f3 = 3'd1; end
            6'd17: begin fmt = F_S;  opc = 7'h23; f3 = 3'd2; end
            6'd18: begin fmt = F_I;  opc = 7'h13; f3 = 3'd0; end
            6'd19: begin fmt = F_I;  opc = 7'h13; f3 = 3'd2; end
            6'd20: begin fmt = F_I;  opc = 7'h13; f3 = 3'd3; end
            6'd21: begin fmt = F_I;  opc = 7'h13; f3 = 3'd4; end
            6'd22: begin fmt = F_I;  opc = 7'h13; f3 = 3'd6; end
            6'd23: begin fmt = F_I;  opc = 7'h13; f3 = 3'd7; end
            6'd24: begin fmt = F_SH; opc = 7'h13; f3 = 3'd1; end
            6'd25: begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; end
            6'd26: begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; alt = 1'b1; end
            6'd27: begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; end
            6'd28: begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; alt = 1'b1; end
            6'd29: begin fmt = F_R;  opc = 7'h33; f3 = 3'd1; end
            6'd30: begin fmt = F_R;  opc = 7'h33; f3 = 3'd2; end
            6'd31: begin fmt = F_R;  opc = 7'h33; f3 = 3'd3; end
            6'd32: begin fmt = F_R;  opc = 7'h33; f3 = 3'd4; end
            6'd33: begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; end
            6'd34: begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; alt = 1'b1; end
            6'd35: begin fmt = F_R;  opc = 7'h33; f3 = 3'd6; end
            6'd36: begin fmt = F_R;  opc = 7'h33; f3 = 3'd7; end
            default: ;
        endcase
    end

    always_comb begin
        word = '0;
        case (fmt)
            F_R:  word = {1'b0, alt, 5'd0, in_rs2, in_rs1, f3, in_rd, opc};
            F_I:  word = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            F_SH: word = {1'b0, alt, 5'd0, in_imm[4:0], in_rs1, f3, in_rd, opc};
            F_S:  word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            F_B:  word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
            F_U:  word = {in_imm[31:12], in_rd, opc};
            F_J:  word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
            default: word = '0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic err_range_q, err_range_d;

    // Signed range checks reduce to "all bits above the field's sign bit agree".
    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            F_I, F_S: imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
            F_B:      imm_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
            F_J:      imm_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
            F_U:      imm_ok = !(|in_imm[11:0]);
            F_SH:     imm_ok = !(|in_imm[31:5]);
            default:  imm_ok = 1'b1;
        endcase
    end

    assign err_range_d = !err_clr && (err_range_q || (accept && legal && !imm_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_range_q <= 1'b0;
        else        err_range_q <= err_range_d;
    end

    assign err_range = err_range_q;
`else
    assign imm_ok    = 1'b1;
    assign err_range = 1'b0;
`endif

    assign legal    = (fmt != F_X);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign fire     = accept && legal && imm_ok;
    assign cur_addr = base_load ? base_addr : next_addr_q;

    always_comb begin
        out_instr_d   = fire ? word : out_instr_q;
        out_addr_d    = fire ? cur_addr : out_addr_q;
        out_valid_d   = fire || (out_valid_q && !out_ready);
        // A rejected request still honours a same-cycle base_load.
        next_addr_d   = fire ? cur_addr + ADDR_W'(1) : cur_addr;
        err_illegal_d = !err_clr && (err_illegal_q || (accept && !legal));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_addr_q    <= '0;
            next_addr_q   <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_addr_q    <= out_addr_d;
            next_addr_q   <= next_addr_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_addr    = out_addr_q;
    assign err_illegal = err_illegal_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors plus randomized requests vs a field-level model.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        base_load = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        err_illegal, err_range;
    logic        err_clr = 1'b0;

    instr_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .base_load(base_load), .base_addr(base_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .err_range(err_range), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit rnd_ready = 0;

    // Reference model state
    logic [41:0] exp_q[$];
    logic [9:0]  m_naddr = '0;
    bit          m_ill = 0, m_rng = 0;

    int F3 [0:36] = '{0,0,0,0, 0,1,4,5,6,7, 0,1,2,4,5, 0,1,2,
                      0,2,3,4,6,7,1,5,5, 0,0,1,2,3,4,5,5,6,7};

    function automatic logic [31:0] ref_word(int op, logic [31:0] rd, logic [31:0] rs1,
                                             logic [31:0] rs2, logic [31:0] imm);
        logic [31:0] opc, base, alt;
        if (op == 0) opc = 32'h37; else if (op == 1) opc = 32'h17;
        else if (op == 2) opc = 32'h6F; else if (op == 3) opc = 32'h67;
        else if (op <= 9) opc = 32'h63; else if (op <= 14) opc = 32'h03;
        else if (op <= 17) opc = 32'h23; else if (op <= 26) opc = 32'h13;
        else opc = 32'h33;
        alt  = (op == 26 || op == 28 || op == 34) ? 32'h4000_0000 : 32'h0;
        base = (32'(F3[op]) << 12) + opc;
        if (op <= 1) return (imm & 32'hFFFF_F000) + (rd << 7) + opc;
        if (op == 2) return (((imm >> 20) & 1) << 31) + (((imm >> 1) & 1023) << 21)
                          + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 255) << 12) + (rd << 7) + opc;
        if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23))
            return ((imm & 32'hFFF) << 20) + (rs1 << 15) + base + (rd << 7);
        if (op <= 9) return (((imm >> 12) & 1) << 31) + (((imm >> 5) & 63) << 25) + (rs2 << 20)
                          + (rs1 << 15) + base + (((imm >> 1) & 15) << 8) + (((imm >> 11) & 1) << 7);
        if (op <= 17) return (((imm >> 5) & 127) << 25) + (rs2 << 20) + (rs1 << 15) + base
                           + ((imm & 31) << 7);
        if (op <= 26) return alt + ((imm & 31) << 20) + (rs1 << 15) + base + (rd << 7);
        return alt + (rs2 << 20) + (rs1 << 15) + base + (rd << 7);
    endfunction

    function automatic bit ref_imm_ok(int op, logic [31:0] imm);
`ifdef ENC_RANGE_CHECK_EN
        int s;
        s = $signed(imm);
        if (op <= 1) return (imm & 32'hFFF) == 0;
        if (op == 2) return s >= -1048576 && s <= 1048574 && (s & 1) == 0;
        if (op >= 4 && op <= 9) return s >= -4096 && s <= 4094 && (s & 1) == 0;
        if (op >= 24 && op <= 26) return imm < 32;
        if (op >= 27) return 1;
        return s >= -2048 && s <= 2047;
`else
        return (op >= 0) || (imm != imm);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_naddr = '0; m_ill = 0; m_rng = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input bit bl, input logic [9:0] ba);
        int  n;
        bit  acc;
        logic [9:0] cur;
        n = 0; acc = 0;
        in_valid = 1'b1; in_op = op[5:0]; in_rd = rd[4:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0];
        in_imm = imm; base_load = bl; base_addr = ba;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                cur = bl ? ba : m_naddr;
                if (op > 36) begin
                    m_ill = 1; m_naddr = cur;
                end else if (!ref_imm_ok(op, imm)) begin
                    m_rng = 1; m_naddr = cur;
                end else begin
                    exp_q.push_back({ref_word(op, rd, rs1, rs2, imm), cur});
                    m_naddr = cur + 10'd1;
                end
                if (err_clr) begin m_ill = 0; m_rng = 0; end
            end else begin
                n++;
                if (n > 200) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: in_ready stuck at 0 for op %0d", op);
                    break;
                end
            end
        end
        #1 in_valid = 1'b0; base_load = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk);
        m_ill = 0; m_rng = 0;
        #1 err_clr = 1'b0;
    endtask

    // Monitor: every handshake pops one expected {word, addr}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got word 0x%08h addr 0x%03h, none expected", out_instr, out_addr);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                if (out_instr !== e[41:10] || out_addr !== e[9:0]) begin
                    errors++;
                    $display("FAIL sb_word: got 0x%08h@0x%03h expected 0x%08h@0x%03h",
                             out_instr, out_addr, e[41:10], e[9:0]);
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [31:0] held;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_err_illegal", 32'(err_illegal), 0);
        chk("rst_err_range", 32'(err_range), 0);

        @(posedge clk); #1;
        send(18, 1, 0, 0, 32'd5, 0, '0);
        @(negedge clk);
        chk("addi_word", out_instr, 32'h0050_0093);
        chk("addi_addr", 32'(out_addr), 0);
        chk("addi_valid", 32'(out_valid), 1);

        do_reset();
        send(27, 3, 1, 2, 0, 0, '0);
        send(28, 3, 1, 2, 0, 0, '0);
        @(negedge clk);
        chk("sub_word", out_instr, 32'h4020_81B3);
        chk("sub_addr", 32'(out_addr), 1);
        @(posedge clk); #1;
        send(4, 0, 1, 2, -32'sd8, 0, '0);
        @(negedge clk);
        chk("beq_word", out_instr, 32'hFE20_8CE3);
        @(posedge clk); #1;
        send(0, 5, 0, 0, 32'h1234_5000, 0, '0);
        @(negedge clk);
        chk("lui_word", out_instr, 32'h1234_52B7);

        // Backpressure: word held stable for 5 cycles
        @(posedge clk); #1 out_ready = 1'b0;
        send(21, 7, 8, 0, 32'h0000_0ABC, 0, '0);
        held = ref_word(21, 7, 8, 0, 32'h0000_0ABC);
        in_valid = 1'b1; in_op = 6'd18;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_hold", out_instr, held);
        end
        in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        send(30, 9, 10, 11, 0, 0, '0);

        // Illegal op: consumed, flagged, counter untouched
        send(40, 1, 1, 1, 0, 0, '0);
        @(negedge clk);
        chk("ill_flag", 32'(err_illegal), 1);
        chk("ill_no_word", 32'(out_valid), 0);
        @(posedge clk); #1;
        send(19, 2, 3, 0, 32'hFFFF_FFFF, 0, '0);
        clear_errs();
        @(negedge clk);
        chk("ill_clr", 32'(err_illegal), 0);
        @(posedge clk); #1 err_clr = 1'b1;
        send(50, 0, 0, 0, 0, 0, '0);
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_priority", 32'(err_illegal), 0);

        // Address wrap from a loaded base
        @(posedge clk); #1;
        send(18, 1, 1, 0, 32'd1, 1, 10'h3FF);
        @(negedge clk);
        chk("base_addr", 32'(out_addr), 32'h3FF);
        @(posedge clk); #1;
        send(18, 1, 1, 0, 32'd2, 0, '0);
        @(negedge clk);
        chk("wrap_addr", 32'(out_addr), 0);

        @(posedge clk); #1;
        send(18, 0, 0, 0, 32'd2048, 0, '0);
        @(negedge clk);
`ifdef ENC_RANGE_CHECK_EN
        chk("range_flag", 32'(err_range), 1);
        chk("range_no_word", 32'(out_valid), 0);
        @(posedge clk); #1;
        clear_errs();
        @(negedge clk);
        chk("range_clr", 32'(err_range), 0);
`else
        chk("trunc_word", out_instr, 32'h8000_0013);
        chk("range_tied", 32'(err_range), 0);
`endif

        // Reset while a word is held under backpressure
        @(posedge clk); #1 out_ready = 1'b0;
        send(27, 1, 2, 3, 0, 0, '0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;

        // Randomized stream
        rnd_ready = 1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            int k;
            k = $urandom_range(0, 2);
            if (k == 0) imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            else if (k == 1) imm = 32'($urandom_range(0, 2000)) * 2 - 32'd2000;
            else imm = $urandom;
            send($urandom_range(0, 39), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), imm, ($urandom_range(0, 15) == 0), 10'($urandom));
        end
        rnd_ready = 0;
        @(posedge clk); #2 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 0);
        chk("rnd_err_illegal", 32'(err_illegal), 32'(m_ill));
        chk("rnd_err_range", 32'(err_range), 32'(m_rng));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
